// File: rtl/noc_pkg.sv
// Shared NoC master-arbiter definitions: unit count, field widths and the
// per-source grant state type.
package noc_pkg;
  localparam int unsigned N_PU   = 4;
  localparam int unsigned FLIT_W = 9;
  localparam int unsigned DEST_W = 2;
  localparam int unsigned CNT_W  = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } src_state_e;
endpackage

// File: rtl/noc_master_arbiter_rr_pick.sv
// Round-robin picker: first set bit of eligible scanning upward from ptr,
// wrapping modulo N_PU. Purely combinational.
module rr_pick
  import noc_pkg::*;
(
  input  logic [N_PU-1:0]   eligible,
  input  logic [DEST_W-1:0] ptr,
  output logic [N_PU-1:0]   winner,
  output logic              valid
);

  logic [DEST_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N_PU; k++) begin
      idx = ptr + DEST_W'(k);
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_master_arbiter.sv
// Arbitrates four processing units onto four destinations: one new grant per
// cycle, round-robin among eligible sources, release on last flit or timeout.
module noc_master_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 300
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PU-1:0]          req,
  input  logic [N_PU*DEST_W-1:0]   dest,
  input  logic [N_PU*FLIT_W-1:0]   flit_in,
  output logic [N_PU-1:0]          master_response,
  output logic [N_PU*DEST_W-1:0]   route_dest,
  output logic [N_PU-1:0]          dst_busy,
  output logic [N_PU-1:0]          timeout_pulse,
  output logic [N_PU-1:0]          self_err
);

  localparam int unsigned TMO_LAST = TIMEOUT_CYCLES - 1;

  src_state_e                state_q [N_PU];
  src_state_e                state_d [N_PU];
  logic [CNT_W-1:0]          cnt_q   [N_PU];
  logic [CNT_W-1:0]          cnt_d   [N_PU];
  logic [N_PU*DEST_W-1:0]    route_q, route_d;
  logic [DEST_W-1:0]         ptr_q, ptr_d;
  logic [N_PU-1:0]           tmo_q, tmo_d;
  logic [N_PU-1:0]           serr_q, serr_d;
  logic [N_PU-1:0]           eligible, win;
  logic                      win_valid;
  logic [DEST_W-1:0]         d_sel;

  // Busy is derived from registered owner state, so a destination freed at an
  // edge is only seen as free by the request sampled at the following edge.
  always_comb begin
    dst_busy = '0;
    for (int unsigned i = 0; i < N_PU; i++) begin
      if (state_q[i] == ACTIVE) dst_busy[route_q[i*DEST_W +: DEST_W]] = 1'b1;
    end
  end

  always_comb begin
    eligible = '0;
    d_sel    = '0;
    for (int unsigned i = 0; i < N_PU; i++) begin
      d_sel       = dest[i*DEST_W +: DEST_W];
      eligible[i] = (state_q[i] == IDLE) && req[i] &&
                    (d_sel != DEST_W'(i)) && !dst_busy[d_sel];
    end
  end

  rr_pick u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (win),
    .valid    (win_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    route_d = route_q;
    ptr_d   = ptr_q;
    tmo_d   = '0;
    serr_d  = '0;
    for (int unsigned i = 0; i < N_PU; i++) begin
      case (state_q[i])
        IDLE: begin
          serr_d[i] = req[i] && (dest[i*DEST_W +: DEST_W] == DEST_W'(i));
          if (win[i]) begin
            state_d[i]                     = ACTIVE;
            cnt_d[i]                       = '0;
            route_d[i*DEST_W +: DEST_W]    = dest[i*DEST_W +: DEST_W];
            ptr_d                          = DEST_W'(i + 1);
          end
        end
        ACTIVE: begin
          // A last flit wins over a coincident timeout: no pulse in that case.
          if ((cnt_q[i] != '0) && flit_in[i*FLIT_W + FLIT_W - 1]) begin
            state_d[i] = IDLE;
          end else if (32'(cnt_q[i]) >= TMO_LAST) begin
            state_d[i] = IDLE;
            tmo_d[i]   = 1'b1;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_PU; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      route_q <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
      serr_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PU; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      route_q <= route_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    master_response = '0;
    for (int unsigned i = 0; i < N_PU; i++) begin
      master_response[i] = (state_q[i] == ACTIVE);
    end
  end

  assign route_dest    = route_q;
  assign timeout_pulse = tmo_q;
  assign self_err      = serr_q;

endmodule

// File: doc/noc_master_arbiter.md
NOC_MASTER_ARBITER -- requirements
Module: noc_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 300: maximum ACTIVE cycles per grant before forced release.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request_transfer from processing unit i (bit i).
REQ-005 dest  input  8  which_processor of unit i at [2i+1:2i].
REQ-006 flit_in  input  36  data_to_router of unit i at [9i+8:9i]; bit 9i+8 is the last-flit flag.
REQ-007 master_response  output  4  registered grant to unit i (bit i).
REQ-008 route_dest  output  8  registered destination latched at grant for unit i at [2i+1:2i].
REQ-009 dst_busy  output  4  bit d high while any source owns destination d.
REQ-010 timeout_pulse  output  4  one-cycle pulse when unit i's grant is force-released.
REQ-011 self_err  output  4  one-cycle pulse when unit i requests with dest == i.

Function
REQ-012 Each source has a 2-state FSM: IDLE, ACTIVE; master_response[i] is high exactly when source i is ACTIVE.
REQ-013 Source i is eligible when IDLE, req[i]=1, dest[i] != i, and destination dest[i] is not busy.
REQ-014 At most one new grant per cycle; the winner is the first eligible source scanning i = ptr, ptr+1, ... modulo 4.
REQ-015 On a grant: winner goes ACTIVE at the next edge, route_dest latches dest[winner], destination marked busy, ptr <= winner+1 (mod 4).
REQ-016 ptr is unchanged in cycles with no grant.
REQ-017 Grant latency: req sampled high at edge N -> master_response high after edge N (one cycle).
REQ-018 Each ACTIVE source runs an 9-bit cycle counter starting at 0 on entry.
REQ-019 Release when ACTIVE, counter >= 1, and last-flit flag of flit_in[i] is 1: IDLE at next edge, destination freed at the same edge.
REQ-020 The last-flit flag is ignored in the first ACTIVE cycle (counter = 0).
REQ-021 Timeout: when counter reaches TIMEOUT_CYCLES-1 without a last flit, release at next edge and pulse timeout_pulse[i] for one cycle.
REQ-022 No bypass: a destination freed at edge M is grantable earliest on the request sampled at edge M+1.
REQ-023 A source that is ACTIVE ignores req[i] and dest[i] changes; route_dest[i] holds.
REQ-024 dest[i] == i with req[i]=1 while IDLE: no grant; self_err[i] pulses every such cycle.
REQ-025 Two sources requesting the same free destination in one cycle: only the round-robin winner is granted; loser retries next cycle.
REQ-026 Two sources with different free destinations in one cycle: still one grant per cycle; the other is granted at the following edge if still eligible.
REQ-027 Counter saturates; no wrap while ACTIVE.

Reset
REQ-028 Reset asserted: all FSMs IDLE, master_response=0, route_dest=0, dst_busy=0, timeout_pulse=0, self_err=0, ptr=0, counters=0, immediately (asynchronous).
REQ-029 Reset mid-transfer drops every grant without a timeout or error pulse; first grant possible on the edge after reset deasserts.

Structure
REQ-030 Shared package noc_pkg holds N_PU=4, FLIT_W=9, DEST_W=2, and the IDLE/ACTIVE state type.
REQ-031 One combinational sub-module rr_pick (4-bit eligible vector, 2-bit ptr -> one-hot winner + valid) implements REQ-014.

Verification
REQ-032 req=0001, dest[0]=2 -> master_response=0001 one cycle later, route_dest[1:0]=2, dst_busy=0100.
REQ-033 Unit 0 ACTIVE to dest 2; flit_in[0] last flag at cycle 5 -> master_response=0000 next edge, dst_busy=0000.
REQ-034 Units 1 and 3 both request dest 0 from reset (ptr=0) -> unit 1 granted, ptr=2; after unit 1 releases, unit 3 granted earliest one edge after the freeing edge.
REQ-035 TIMEOUT_CYCLES=8, unit 2 ACTIVE, no last flit -> release after 8 ACTIVE cycles, timeout_pulse=0100 for exactly one cycle.
REQ-036 req=1000, dest[3]=3 -> no grant, self_err=1000 each cycle held; reset asserted during a unit 0 grant -> all outputs 0 same cycle.
